// File: rtl/mem_responder.sv
// mem_responder
//   Shared block-memory responder for NPROC requester ports. Pending read
//   or write requests are arbitrated round-robin in IDLE. The winner is
//   served in a single SERVE cycle, which carries a one-cycle grant.
//   A read returns a 5-word block on o_data. A write commits 1..5 words.
//
// Handshake: a port raises i_req_rd and/or i_req_wr and holds i_addr,
//   i_wr_size and i_data stable until the block samples them in IDLE.
//   The grant (o_grant_rd / o_grant_wr) pulses for exactly one cycle, in
//   the cycle after sampling. The requester drops its request after seeing
//   the grant. o_valid equals o_grant_rd.
//
// Ports:
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_req_rd/i_req_wr   per-port read / write request
//   i_addr              per-port word address (low log2(DEPTH) bits used)
//   i_wr_size           per-port write length, clamped to 5
//   i_data              per-port 5-word write block
//   o_grant_rd/o_grant_wr  one-hot grant pulses
//   o_valid             read data valid (same as o_grant_rd)
//   o_data              read block, broadcast to all ports
//   o_dbg_state         current FSM state (0 = IDLE, 1 = SERVE)
//   o_rd_count/o_wr_count  serve counters, only with MEM_RESPONDER_STATS_EN
//
// Optional feature macro: MEM_RESPONDER_STATS_EN
module mem_responder #(
    parameter int NPROC  = 4,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NPROC-1:0]                  i_req_rd,
    input  logic [NPROC-1:0]                  i_req_wr,
    input  logic [NPROC-1:0][ADDR_W-1:0]      i_addr,
    input  logic [NPROC-1:0][2:0]             i_wr_size,
    input  logic [NPROC-1:0][4:0][31:0]       i_data,
    output logic [NPROC-1:0]                  o_grant_rd,
    output logic [NPROC-1:0]                  o_grant_wr,
    output logic [NPROC-1:0]                  o_valid,
    output logic [4:0][31:0]                  o_data,
    output logic [0:0]                        o_dbg_state
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]                       o_rd_count,
    output logic [31:0]                       o_wr_count
`endif
);

    localparam int IDX_W  = (NPROC > 1) ? $clog2(NPROC) : 1;
    localparam int MEM_AW = $clog2(DEPTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic              wr_q, wr_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [4:0][31:0]  wdata_q, wdata_d;
    logic [4:0][31:0]  rdata_q, rdata_d;

    logic [31:0] mem [DEPTH];

    logic             found;
    logic [IDX_W-1:0] pick;
    logic [2:0]       wr_len;

    // Upper address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_addr;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        found   = 1'b0;
        pick    = '0;

        if (state_q == IDLE) begin
            // Search from last+1 upward with wrap; the first eligible port wins.
            for (int i = 1; i <= NPROC; i++) begin
                if (!found && (i_req_rd[(int'(last_q) + i) % NPROC] ||
                               i_req_wr[(int'(last_q) + i) % NPROC])) begin
                    found = 1'b1;
                    pick  = IDX_W'((int'(last_q) + i) % NPROC);
                end
            end
            if (found) begin
                state_d = SERVE;
                last_d  = pick;
                win_d   = pick;
                // A write takes priority; a simultaneous read stays pending.
                wr_d    = i_req_wr[pick];
                addr_d  = i_addr[pick][MEM_AW-1:0];
                size_d  = i_wr_size[pick];
                wdata_d = i_data[pick];
                if (!i_req_wr[pick]) begin
                    for (int k = 0; k < 5; k++) begin
                        rdata_d[k] = mem[i_addr[pick][MEM_AW-1:0] + MEM_AW'(k)];
                    end
                end
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NPROC - 1);
            win_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign wr_len = (size_q > 3'd5) ? 3'd5 : size_q;

    // Commit at the end of SERVE. Reset forces state_q to IDLE right away,
    // so a write interrupted by reset is never committed.
    always_ff @(posedge i_clk) begin
        if (!i_rst && state_q == SERVE && wr_q) begin
            for (int k = 0; k < 5; k++) begin
                if (3'(k) < wr_len) begin
                    mem[addr_q + MEM_AW'(k)] <= wdata_q[k];
                end
            end
        end
    end

    // Grants decode directly from flops so reset clears them asynchronously.
    always_comb begin
        o_grant_rd = '0;
        o_grant_wr = '0;
        if (state_q == SERVE) begin
            if (wr_q) begin
                o_grant_wr[win_q] = 1'b1;
            end else begin
                o_grant_rd[win_q] = 1'b1;
            end
        end
    end

    assign o_valid     = o_grant_rd;
    assign o_data      = rdata_q;
    assign o_dbg_state = state_q;

`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == SERVE) begin
            if (wr_q) begin
                wr_count_d = wr_count_q + 32'd1;
            end else begin
                rd_count_d = rd_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign o_rd_count = rd_count_q;
    assign o_wr_count = wr_count_q;
`endif

endmodule

// File: doc/mem_responder.md
# mem_responder

Shared block-memory responder serving the read/write request ports of up to NPROC `proc` instances. Arbitrates round-robin among pending requests and issues one-cycle grants. On a read grant it returns a 5-word block with valid; on a write grant it commits 1–5 words. It is the memory-side end of the `o_req_rd`/`o_req_wr`/`i_grant_*`/`i_valid`/`i_data` protocol.

## Interface
- `NPROC`, 4: number of requester ports (1–8).
- `ADDR_W`, 16: address width, matching `addr_t`.
- `DEPTH`, 1024: memory depth in 32-bit words (power of two).
- `i_clk` in 1: clock; all logic on the rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_req_rd` in [NPROC-1:0]: read request per port.
- `i_req_wr` in [NPROC-1:0]: write request per port.
- `i_addr` in [NPROC-1:0][ADDR_W-1:0]: word address per port.
- `i_wr_size` in [NPROC-1:0][2:0]: words to write per port.
- `i_data` in [NPROC-1:0][4:0][31:0]: write block per port.
- `o_grant_rd` out [NPROC-1:0]: one-hot read grant pulse.
- `o_grant_wr` out [NPROC-1:0]: one-hot write grant pulse.
- `o_valid` out [NPROC-1:0]: read data valid; equals `o_grant_rd`.
- `o_data` out [4:0][31:0]: read block, broadcast to all ports.

## Operation
- FSM states IDLE and SERVE. Reset state: IDLE.
- IDLE:
  - Sample all requests. If none are pending, stay in IDLE.
  - Otherwise pick the winner by round-robin: search from port `last+1` upward, wrapping. A port is eligible if `i_req_rd | i_req_wr`.
  - Capture the winner's index, op, address, size and data into registers.
  - For a read, register words `mem[(addr+k) mod DEPTH]` for k = 0..4 into `o_data`, with word k in `o_data[k]`.
  - Go to SERVE. Update `last` to the winner's index.
- SERVE:
  - Assert exactly one grant bit for the winner. Return to IDLE unconditionally.
  - Requests are not re-sampled in SERVE. A requester still sees its request high in this cycle and must drop it after the grant.
- Read: `o_grant_rd[w]` = `o_valid[w]` = 1 for the SERVE cycle. `o_data` holds the block and stays unchanged until the next read capture.
- Write:
  - `o_grant_wr[w]` = 1 for the SERVE cycle.
  - The captured words `data[0..n-1]` are written to `(addr+k) mod DEPTH` at the end of the SERVE cycle.
  - n = `wr_size` clamped to 5. Size 0 grants but writes nothing.
- A port asserting both `i_req_rd` and `i_req_wr` is served as a write. The read stays pending and wins a later arbitration.
- Addresses: the low log2(DEPTH) bits are used and upper bits are ignored. Block accesses wrap modulo DEPTH.
- A read captured in IDLE sees all writes committed in earlier SERVE cycles, so there is no read-after-write hazard.
- Memory contents are not affected by reset and are undefined until written.

## Timing
- Reset values:
  - `o_grant_rd` = 0, `o_grant_wr` = 0, `o_valid` = 0, `o_data` = 0.
  - FSM = IDLE, `last` = NPROC-1, so port 0 wins first.
- Latency: a request high at rising edge N gives a grant during cycle N+1.
- Throughput: one transaction per 2 cycles.
- Requests sampled at edge N+2 are arbitrated afresh.
- The requester must hold `i_addr`, `i_wr_size` and `i_data` stable from raising the request until the edge at which the block samples it in IDLE.
- Reset asserted mid-SERVE:
  - Outputs clear immediately (asynchronously).
  - A pending write is not committed.
  - `last` returns to NPROC-1.
- A request withdrawn before it is sampled is simply not served.

## Configuration
- `MEM_RESPONDER_STATS_EN`: when defined, adds two outputs, `o_rd_count` [31:0] and `o_wr_count` [31:0].
  - Each increments by 1 per SERVE cycle of its op type, including size-0 writes.
  - Both wrap at 2^32 and reset to 0.
- When not defined, these ports and counters do not exist and the behaviour is otherwise identical.

## Test plan
- Write then read:
  - Port 0 writes size 5, addr 10, data {5,4,3,2,1} (`data[4..0]`). Grant appears 1 cycle after the request.
  - Then port 0 reads addr 10. Required: `o_valid[0]` = 1 with `o_data[4..0]` = {5,4,3,2,1}.
- Partial write:
  - Write size 1 of 0xDEAD to addr 10. Reading addr 10 returns `o_data[0]` = 0xDEAD and `o_data[1]` = 2 (unchanged).
  - Write size 0: grant is issued and memory is unchanged.
- Contention:
  - Ports 0–3 all request reads continuously. Grants go 0,1,2,3,0, one every 2 cycles, each one-hot.
  - Port 2 requesting both reads and writes is granted the write first.
- Wrap-around:
  - Write size 5 at addr DEPTH-2 with data {e,d,c,b,a} hits words DEPTH-2, DEPTH-1, 0, 1, 2.
  - Reading addr DEPTH-2 returns the same block.
  - Reading addr 2^ADDR_W-2 (upper bits ignored) returns the same block.
- Reset mid-operation:
  - Assert `i_rst` during the SERVE cycle of a write to addr 20. All grants go low the same cycle.
  - A later read of addr 20 shows the write was not committed (pre-write value).
  - The first grant after reset goes to port 0.
- Stats (`MEM_RESPONDER_STATS_EN`): after 3 reads and 2 writes, `o_rd_count` = 3 and `o_wr_count` = 2. Reset clears both to 0.
